// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared FSM state type and I2C register map for the APB master bridge
// No ports; imported by apb_wait_timer and apb_master_bridge.
package apb_master_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
   localparam logic [31:0] ADDR_TX      = 32'd0;
   localparam logic [31:0] ADDR_RX      = 32'd4;
   localparam logic [31:0] ADDR_CONFIG  = 32'd8;
   localparam logic [31:0] ADDR_TIMEOUT = 32'd12;
endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts PREADY-low ACCESS cycles and flags the last one allowed
// Ports: clk_i/rst_i clock and sync reset; clr_i zeroes the count; en_i advances it;
// expire_o is high while the count equals WAIT_MAX-1 (never when WAIT_MAX is 0).
module apb_wait_timer import apb_master_pkg::*; #(
   parameter int WAIT_MAX = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);
   localparam int CW = WAIT_MAX > 1 ? $clog2(WAIT_MAX) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
   assign expire_o = (WAIT_MAX != 0) && (cnt_q == CW'(WAIT_MAX - 1));
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command port to APB3 requester with PREADY timeout
// Ports: pclk_i/preset_i clock and sync reset; cmd_* command handshake (write, addr, wdata);
// rsp_* registered one-cycle completion (rdata, err, timeout); pselx_o/penable_o/pwrite_o/
// paddr_o/pwdata_o registered APB request; prdata_i/pready_i/pslverr_i APB completer reply.
module apb_master_bridge import apb_master_pkg::*; #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int WAIT_MAX = 16
) (
   input  logic              pclk_i,
   input  logic              preset_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              rsp_timeout_o,
   output logic              pselx_o,
   output logic              penable_o,
   output logic              pwrite_o,
   output logic [ADDR_W-1:0] paddr_o,
   output logic [DATA_W-1:0] pwdata_o,
   input  logic [DATA_W-1:0] prdata_i,
   input  logic              pready_i,
   input  logic              pslverr_i
);
   state_e state_q, state_d;
   logic psel_q, psel_d, pen_q, pen_d, pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
   logic rvalid_q, rvalid_d, rerr_q, rerr_d, rto_q, rto_d;
   logic expire;
   apb_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
      .clk_i    (pclk_i),
      .rst_i    (preset_i),
      .clr_i    (state_q != ACCESS),
      .en_i     (state_q == ACCESS && !pready_i),
      .expire_o (expire)
   );
   assign cmd_ready_o = (state_q == IDLE) && !preset_i;
   always_comb begin
      state_d  = state_q;
      psel_d   = 1'b0;
      pen_d    = 1'b0;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      rvalid_d = 1'b0;
      rerr_d   = 1'b0;
      rto_d    = 1'b0;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: if (cmd_valid_i && cmd_ready_o) begin
            state_d  = SETUP;
            psel_d   = 1'b1;
            pwrite_d = cmd_write_i;
            paddr_d  = cmd_addr_i;
            pwdata_d = cmd_wdata_i;
         end
         SETUP: begin
            state_d = ACCESS;
            psel_d  = 1'b1;
            pen_d   = 1'b1;
         end
         ACCESS: if (pready_i) begin
            state_d  = IDLE;
            rvalid_d = 1'b1;
            rdata_d  = pwrite_q ? '0 : prdata_i;
            rerr_d   = pslverr_i;
         end else if (expire) begin
            state_d  = IDLE;
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
            rto_d    = 1'b1;
            rdata_d  = '0;
         end else begin
            psel_d = 1'b1;
            pen_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge pclk_i) begin
      if (preset_i) begin
         state_q  <= IDLE;
         psel_q   <= 1'b0;
         pen_q    <= 1'b0;
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         rvalid_q <= 1'b0;
         rerr_q   <= 1'b0;
         rto_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         psel_q   <= psel_d;
         pen_q    <= pen_d;
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         rvalid_q <= rvalid_d;
         rerr_q   <= rerr_d;
         rto_q    <= rto_d;
         rdata_q  <= rdata_d;
      end
   end
   assign pselx_o       = psel_q;
   assign penable_o     = pen_q;
   assign pwrite_o      = pwrite_q;
   assign paddr_o       = paddr_q;
   assign pwdata_o      = pwdata_q;
   assign rsp_valid_o   = rvalid_q;
   assign rsp_rdata_o   = rdata_q;
   assign rsp_err_o     = rerr_q;
   assign rsp_timeout_o = rto_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: randomized self-checking bench with an APB completer model
module tb_apb_master_bridge;
   import apb_master_pkg::*;
   localparam int WM = 4;
   logic clk = 1'b0, rst = 1'b1;
   logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0, cmd_wdata = '0;
   logic rsp_valid, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic pselx, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [31:0] prdata = '0;
   logic pready = 1'b0, pslverr = 1'b0;
   int tests = 0, fails = 0;

   apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .WAIT_MAX(WM)) dut (
      .pclk_i(clk), .preset_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
      .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
      .pselx_o(pselx), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr), .pwdata_o(pwdata),
      .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
   );

   always #5 clk = ~clk;

   // Reference: cycles from accept to response, and what the response carries.
   function automatic void predict(input logic w, input int waits, input logic err, input logic [31:0] rd,
                                   output int lat, output logic [31:0] rdata, output logic e, output logic to);
      if (WM != 0 && waits >= WM) begin
         lat = WM + 2; rdata = '0; e = 1'b1; to = 1'b1;
      end else begin
         lat = 3 + waits; rdata = w ? 32'h0 : rd; e = err; to = 1'b0;
      end
   endfunction

   // Issue one command, play the completer inserting `waits` PREADY-low cycles, observe the result.
   task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int waits,
                          input logic err, input logic [31:0] rd,
                          output int lat, output logic [31:0] r_rdata, output logic r_err, output logic r_to,
                          output logic r_rdy, output int n_sel, output int n_en, output int n_bad);
      int k, ac;
      logic got, prev_sel, prev_en;
      lat = -1; r_rdata = 'x; r_err = 1'bx; r_to = 1'bx; r_rdy = 1'bx;
      n_sel = 0; n_en = 0; n_bad = 0; prev_sel = 0; prev_en = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      k = 0;
      while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
      @(negedge clk);
      cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
      k = 1; ac = 0; got = 0;
      while (!got && k <= 40) begin
         if (pselx) n_sel++;
         if (penable) n_en++;
         if (penable && !pselx) n_bad++;
         if (penable && !prev_en && !(prev_sel && !prev_en)) n_bad++;
         if (pselx && (paddr !== a || pwrite !== w || pwdata !== d)) n_bad++;
         if (rsp_valid) begin
            got = 1; lat = k; r_rdata = rsp_rdata; r_err = rsp_err; r_to = rsp_timeout; r_rdy = cmd_ready;
         end
         prev_sel = pselx; prev_en = penable;
         if (pselx && penable) begin pready = (ac == waits); ac++; end
         else pready = 1'($urandom);
         prdata  = (pselx && penable && pready) ? rd  : $urandom;
         pslverr = (pselx && penable && pready) ? err : 1'($urandom);
         if (!got) begin @(negedge clk); k++; end
      end
      @(negedge clk);
      if (rsp_valid || pselx || penable || rsp_err || rsp_timeout) n_bad++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if (pselx !== 0 || penable !== 0 || pwrite !== 0 || rsp_valid !== 0 || rsp_err !== 0 || rsp_timeout !== 0)
         begin fails++; $display("FAIL reset_ctrl: sel=%b en=%b wr=%b rv=%b err=%b to=%b, want all 0",
                                 pselx, penable, pwrite, rsp_valid, rsp_err, rsp_timeout); end
      tests++;
      if (paddr !== 0 || pwdata !== 0 || rsp_rdata !== 0)
         begin fails++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, want 0", paddr, pwdata, rsp_rdata); end
      tests++;
      if (cmd_ready !== 0) begin fails++; $display("FAIL reset_ready: cmd_ready=%b want 0", cmd_ready); end
      rst = 1'b0; #1;
      tests++;
      if (cmd_ready !== 1) begin fails++; $display("FAIL reset_release: cmd_ready=%b want 1", cmd_ready); end
   endtask

   task automatic test_write_config();
      int lat, ns, ne, nb; logic [31:0] rd; logic e, to, rdy;
      run_txn(1'b1, ADDR_CONFIG, 32'h0000_2A5C, 0, 1'b0, 32'h1234_5678, lat, rd, e, to, rdy, ns, ne, nb);
      tests++;
      if (ns !== 2 || ne !== 1) begin fails++; $display("FAIL wr_cfg_shape: psel=%0d pen=%0d want 2/1", ns, ne); end
      tests++;
      if (lat !== 3) begin fails++; $display("FAIL wr_cfg_latency: got %0d want 3", lat); end
      tests++;
      if (e !== 0 || to !== 0 || rd !== 0 || rdy !== 1)
         begin fails++; $display("FAIL wr_cfg_rsp: err=%b to=%b rdata=%h rdy=%b want 0/0/0/1", e, to, rd, rdy); end
      tests++;
      if (nb !== 0) begin fails++; $display("FAIL wr_cfg_protocol: %0d violations want 0", nb); end
   endtask

   task automatic test_read_waits();
      int lat, ns, ne, nb; logic [31:0] rd; logic e, to, rdy;
      run_txn(1'b0, ADDR_RX, $urandom, 3, 1'b0, 32'hDEAD_BEEF, lat, rd, e, to, rdy, ns, ne, nb);
      tests++;
      if (lat !== 6) begin fails++; $display("FAIL rd_wait_latency: got %0d want 6", lat); end
      tests++;
      if (rd !== 32'hDEAD_BEEF || e !== 0 || to !== 0)
         begin fails++; $display("FAIL rd_wait_rsp: rdata=%h err=%b to=%b want deadbeef/0/0", rd, e, to); end
      tests++;
      if (nb !== 0 || ns !== 5) begin fails++; $display("FAIL rd_wait_stable: bad=%0d psel=%0d want 0/5", nb, ns); end
   endtask

   task automatic test_slverr();
      int lat, ns, ne, nb; logic [31:0] rd; logic e, to, rdy;
      run_txn(1'b1, ADDR_TX, $urandom, 1, 1'b1, $urandom, lat, rd, e, to, rdy, ns, ne, nb);
      tests++;
      if (e !== 1 || to !== 0 || rd !== 0 || lat !== 4)
         begin fails++; $display("FAIL slverr: err=%b to=%b rdata=%h lat=%0d want 1/0/0/4", e, to, rd, lat); end
   endtask

   task automatic test_timeout();
      int lat, ns, ne, nb; logic [31:0] rd; logic e, to, rdy;
      run_txn(1'b0, ADDR_TIMEOUT, $urandom, 1000, 1'b0, $urandom, lat, rd, e, to, rdy, ns, ne, nb);
      tests++;
      if (lat !== WM + 2 || ne !== WM)
         begin fails++; $display("FAIL timeout_latency: lat=%0d access=%0d want %0d/%0d", lat, ne, WM + 2, WM); end
      tests++;
      if (e !== 1 || to !== 1 || rd !== 0)
         begin fails++; $display("FAIL timeout_rsp: err=%b to=%b rdata=%h want 1/1/0", e, to, rd); end
      tests++;
      if (nb !== 0) begin fails++; $display("FAIL timeout_protocol: %0d violations want 0", nb); end
   endtask

   task automatic test_reset_abort();
      int k, nv;
      @(negedge clk);
      pready = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = ADDR_RX;
      @(negedge clk);
      cmd_valid = 1'b0;
      k = 0;
      while (!(pselx && penable) && k < 10) begin @(negedge clk); k++; end
      tests++;
      if (!(pselx && penable)) begin fails++; $display("FAIL abort_reach_access: sel=%b en=%b want 1/1", pselx, penable); end
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if (pselx !== 0 || penable !== 0 || rsp_valid !== 0 || cmd_ready !== 0)
         begin fails++; $display("FAIL abort_reset: sel=%b en=%b rv=%b rdy=%b want 0/0/0/0", pselx, penable, rsp_valid, cmd_ready); end
      rst = 1'b0; #1;
      tests++;
      if (cmd_ready !== 1) begin fails++; $display("FAIL abort_ready: cmd_ready=%b want 1", cmd_ready); end
      nv = 0;
      repeat (8) begin @(negedge clk); if (rsp_valid || pselx) nv++; end
      tests++;
      if (nv !== 0) begin fails++; $display("FAIL abort_no_rsp: %0d cycles with rsp/psel want 0", nv); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ad[3], dt[3];
      int acc[3];
      int na, nr, nb, k;
      for (int i = 0; i < 3; i++) begin ad[i] = $urandom & 32'hFFFF_FFFC; dt[i] = $urandom; acc[i] = -1; end
      na = 0; nr = 0; nb = 0; k = 0;
      pready = 1'b1; pslverr = 1'b0;
      @(negedge clk);
      while (nr < 3 && k < 40) begin
         if (rsp_valid) begin
            nr++;
            if (rsp_err !== 0 || rsp_timeout !== 0 || rsp_rdata !== 0) nb++;
         end
         if (penable && !pselx) nb++;
         if (pselx && (na == 0 || paddr !== ad[na-1] || pwdata !== dt[na-1] || pwrite !== 1)) nb++;
         if (na < 3) begin
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = ad[na]; cmd_wdata = dt[na];
            if (cmd_ready) begin acc[na] = k; na++; end
         end else cmd_valid = 1'b0;
         @(negedge clk); k++;
      end
      cmd_valid = 1'b0;
      tests++;
      if (nr !== 3) begin fails++; $display("FAIL b2b_rsp_count: got %0d want 3", nr); end
      tests++;
      if (acc[0] !== 0 || acc[1] !== 3 || acc[2] !== 6)
         begin fails++; $display("FAIL b2b_accept: cycles %0d,%0d,%0d want 0,3,6", acc[0], acc[1], acc[2]); end
      tests++;
      if (nb !== 0) begin fails++; $display("FAIL b2b_protocol: %0d violations want 0", nb); end
   endtask

   task automatic test_random();
      int lat, ns, ne, nb, el, waits; logic [31:0] rd, erd, a, d, prd; logic e, to, rdy, ee, eto, w, err;
      for (int i = 0; i < 40; i++) begin
         w = 1'($urandom); err = 1'($urandom); waits = $urandom_range(0, WM + 1);
         a = $urandom; d = $urandom; prd = $urandom;
         predict(w, waits, err, prd, el, erd, ee, eto);
         run_txn(w, a, d, waits, err, prd, lat, rd, e, to, rdy, ns, ne, nb);
         tests++;
         if (lat !== el || rd !== erd || e !== ee || to !== eto || rdy !== 1)
            begin fails++; $display("FAIL rand_rsp[%0d]: lat=%0d rd=%h err=%b to=%b rdy=%b want %0d/%h/%b/%b/1",
                                    i, lat, rd, e, to, rdy, el, erd, ee, eto); end
         tests++;
         if (ns !== el - 1 || ne !== el - 2 || nb !== 0)
            begin fails++; $display("FAIL rand_shape[%0d]: psel=%0d pen=%0d bad=%0d want %0d/%0d/0",
                                    i, ns, ne, nb, el - 1, el - 2); end
      end
   endtask

   initial begin
      test_reset();
      test_write_config();
      test_read_waits();
      test_slverr();
      test_timeout();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB3 requester (initiator) that drives the I2C core's APB register slave from a simple valid/ready command port. It is used by the on-chip sequencer and the testbench host model.
- Converts each accepted command into one SETUP + ACCESS transfer and waits for PREADY, bounded by a timeout.
- Returns read data and error status on a one-cycle response strobe.

Parameters:
- ADDR_W, 32, width of PADDR and CMD_ADDR.
- DATA_W, 32, width of PWDATA, PRDATA, CMD_WDATA and RSP_RDATA.
- WAIT_MAX, 16, maximum number of ACCESS cycles with PREADY low before abort. 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  bridge can accept a command.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  ADDR_W  target address.
- CMD_WDATA  in  DATA_W  write data.
- RSP_VALID  out  1  one-cycle completion strobe.
- RSP_RDATA  out  DATA_W  read data; 0 for writes and aborts.
- RSP_ERR  out  1  PSLVERR was sampled, or the transfer timed out.
- RSP_TIMEOUT  out  1  completion was a timeout abort.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Reset (PRESET high at a PCLK edge):
  - state goes to IDLE.
  - PSELx, PENABLE, PWRITE, RSP_VALID, RSP_ERR and RSP_TIMEOUT go to 0.
  - PADDR, PWDATA and RSP_RDATA go to 0.
  - Wait counter clears.
  - CMD_READY is 0 while PRESET is high.
- An abort mid-transfer via reset produces no RSP_VALID.
- All APB outputs and all RSP_* outputs are registered. CMD_READY = (state==IDLE) && !PRESET, decoded combinationally from state.
- FSM states are IDLE, SETUP, ACCESS.
- IDLE:
  - When CMD_VALID && CMD_READY at an edge, latch addr/write/wdata into PADDR/PWRITE/PWDATA and set PSELx=1, PENABLE=0. Next state is SETUP.
  - With no command, all APB outputs hold their values except PSELx=PENABLE=0.
- SETUP: lasts exactly one cycle. Set PENABLE=1, then go to ACCESS. Counter is 0.
- ACCESS: PSELx=1, PENABLE=1; PADDR, PWRITE and PWDATA remain stable. At each edge:
  - If PREADY=1: complete. PSELx=PENABLE=0; RSP_VALID=1 for one cycle; RSP_RDATA = PWRITE ? 0 : PRDATA; RSP_ERR=PSLVERR; RSP_TIMEOUT=0. Next state is IDLE.
  - Else if WAIT_MAX!=0 and counter==WAIT_MAX-1: abort. PSELx=PENABLE=0; RSP_VALID=1, RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0. Next state is IDLE.
  - Else: counter increments and the state stays ACCESS.
- Latency: command accepted at edge N gives SETUP in cycle N+1 and ACCESS in cycle N+2. With zero wait states, RSP_VALID is high in cycle N+3. Each PREADY-low cycle adds one cycle.
- Throughput: one transfer per at least 3 cycles. After completion the bridge passes through IDLE for one cycle, so CMD_READY is high in the same cycle as RSP_VALID.
- Outside a completion cycle, RSP_VALID=0, RSP_ERR=0 and RSP_TIMEOUT=0, and RSP_RDATA holds its last value.
- Commands presented while CMD_READY=0 are ignored. The bridge never queues.
- PSLVERR and PRDATA are sampled only in ACCESS when PREADY=1. Their value at any other time is don't-care.
- Protocol invariants:
  - PENABLE implies PSELx.
  - PENABLE never rises without one preceding SETUP cycle.
  - PADDR, PWRITE and PWDATA are stable while PSELx=1.

Decomposition:
- Package apb_master_pkg holds:
  - state typedef (IDLE, SETUP, ACCESS).
  - I2C register map constants: ADDR_TX=0, ADDR_RX=4, ADDR_CONFIG=8, ADDR_TIMEOUT=12.
- One sub-module, apb_wait_timer: clear/enable counter with a WAIT_MAX compare and an expire output, disabled when WAIT_MAX=0.

Test Plan:
- Write 0x0000_2A5C to ADDR_CONFIG, slave PREADY=1 immediately → PSELx high for 2 cycles. PENABLE is high in the second cycle only. RSP_VALID is high 3 cycles after accept, with RSP_ERR=0 and RSP_RDATA=0.
- Read ADDR_RX, slave holds PREADY low for 3 cycles, then returns PRDATA=0xDEAD_BEEF → RSP_VALID arrives 6 cycles after accept, RSP_RDATA=0xDEAD_BEEF, and PADDR=4 is stable throughout.
- Write ADDR_TX with PSLVERR=1 at PREADY → RSP_ERR=1, RSP_TIMEOUT=0.
- With WAIT_MAX=4, PREADY stuck at 0 → abort after 4 ACCESS cycles: RSP_VALID=1, RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0, PSELx=0 the next cycle.
- PRESET asserted during ACCESS → next cycle PSELx=PENABLE=0, state IDLE, no RSP_VALID ever issued. CMD_READY is 1 once PRESET drops.
- CMD_VALID held high for 3 back-to-back writes → each accepted only when CMD_READY=1, three RSP_VALID pulses in order, and the invariants hold on every cycle.
